// File: rtl/br_pkg.sv
`default_nettype none
// ============================================================================
// Module      : br_pkg
// Description : Shared defaults and control-word bit indices for the buffer
//               register FIFO between the MBR and the ALU/register side.
// Revision    : 1.0 - initial release
// ============================================================================
package br_pkg;

  // Default geometry of the buffer queue
  localparam int BR_WIDTH = 16;
  localparam int BR_DEPTH = 4;

  // Control-word bit positions, shared with the microword definition
  localparam int BR_LOAD_BIT = 7;
  localparam int BR_POP_BIT  = 8;
  localparam int BR_CLR_BIT  = 9;

  // Pointer width for a DEPTH-entry queue; a one-entry queue still gets one bit
  function automatic int br_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/br_ptr_ctr.sv
`default_nettype none
// ============================================================================
// Module      : br_ptr_ctr
// Description : Modulo-DEPTH wrapping pointer with enable and synchronous
//               clear. Used for both the read and the write pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module br_ptr_ctr
  import br_pkg::*;
#(
  parameter int DEPTH = BR_DEPTH,
  parameter int PW    = br_ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Next pointer: clear wins, otherwise advance and wrap at DEPTH-1
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (en) begin
      if (ptr_q == PW'(DEPTH - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + PW'(1);
      end
    end
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule
`default_nettype wire

// File: rtl/br_fifo.sv
`default_nettype none
// ============================================================================
// Module      : br_fifo
// Description : DEPTH-entry circular buffer register between MBR and the
//               datapath. Pushes/pops/clears under control-word strobes,
//               presents the oldest word (or the last popped one when empty),
//               and keeps sticky overflow/underflow bits.
// Revision    : 1.0 - initial release
// ============================================================================
module br_fifo
  import br_pkg::*;
#(
  parameter int WIDTH    = BR_WIDTH,
  parameter int DEPTH    = BR_DEPTH,
  parameter int LOAD_BIT = BR_LOAD_BIT,
  parameter int POP_BIT  = BR_POP_BIT,
  parameter int CLR_BIT  = BR_CLR_BIT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                control_signal,
  input  logic [WIDTH-1:0]           mbr_in,
  output logic [WIDTH-1:0]           br_out,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = br_ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic             ld;
  logic             pp;
  logic             cl;
  logic             unused_ctrl;
  logic             pop_ok;
  logic             push_ok;
  logic             adv_rd;
  logic             adv_wr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [WIDTH-1:0] last_q;
  logic [WIDTH-1:0] last_d;
  logic             overflow_q;
  logic             overflow_d;
  logic             underflow_q;
  logic             underflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign ld          = control_signal[LOAD_BIT];
  assign pp          = control_signal[POP_BIT];
  assign cl          = control_signal[CLR_BIT];
  // Only three bits of the microword matter here
  assign unused_ctrl = ^control_signal;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  // Push is judged against the pre-edge count, so a same-cycle pop frees a slot
  assign pop_ok  = pp & ~empty;
  assign push_ok = ld & (~full | pop_ok);
  assign adv_rd  = pop_ok & ~cl;
  assign adv_wr  = push_ok & ~cl;

  br_ptr_ctr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv_rd),
    .clr   (cl),
    .ptr   (rd_ptr)
  );

  br_ptr_ctr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv_wr),
    .clr   (cl),
    .ptr   (wr_ptr)
  );

  // Next state for storage, occupancy, held output and sticky error bits
  always_comb begin
    count_d     = count_q;
    last_d      = last_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    mem_d       = mem_q;
    if (cl) begin
      // Clear drops everything except the raw storage contents
      count_d     = '0;
      last_d      = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (pop_ok) begin
        last_d = mem_q[rd_ptr];
      end
      if (push_ok) begin
        mem_d[wr_ptr] = mbr_in;
      end
      if (pp && empty) begin
        underflow_d = 1'b1;
      end
      if (ld && !push_ok) begin
        overflow_d = 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count_d = count_q + CW'(1);
      end else if (pop_ok && !push_ok) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      last_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      last_q      <= last_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Entry storage; never read while its slot is invalid, so no reset needed
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign br_out    = empty ? last_q : mem_q[rd_ptr];
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_br_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_br_fifo
// Description : Directed bench for br_fifo. Drives DEPTH=4, 1 and 3 instances
//               with one shared stimulus stream and compares each against a
//               queue-based scoreboard plus fixed expectations for DEPTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_br_fifo;
  import br_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cs = '0;
  logic [15:0] din = '0;

  logic [15:0] bo0, bo1, bo2;
  logic        e0, e1, e2, f0, f1, f2, o0, o1, o2, u0, u1, u2;
  logic [2:0]  c0;
  logic [0:0]  c1;
  logic [1:0]  c2;

  int checks = 0;
  int failures = 0;

  // Scoreboard state per instance (index 0: DEPTH=4, 1: DEPTH=1, 2: DEPTH=3)
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] q2[$];
  logic [15:0] last_m [3];
  logic        ovf_m [3];
  logic        unf_m [3];
  int          dep [3] = '{4, 1, 3};

  always #5 clk = ~clk;

  br_fifo #(.WIDTH(16), .DEPTH(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .control_signal(cs), .mbr_in(din),
    .br_out(bo0), .empty(e0), .full(f0), .count(c0), .overflow(o0), .underflow(u0)
  );
  br_fifo #(.WIDTH(16), .DEPTH(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .control_signal(cs), .mbr_in(din),
    .br_out(bo1), .empty(e1), .full(f1), .count(c1), .overflow(o1), .underflow(u1)
  );
  br_fifo #(.WIDTH(16), .DEPTH(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .control_signal(cs), .mbr_in(din),
    .br_out(bo2), .empty(e2), .full(f2), .count(c2), .overflow(o2), .underflow(u2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete(); q2.delete();
    for (int i = 0; i < 3; i++) begin
      last_m[i] = '0; ovf_m[i] = 1'b0; unf_m[i] = 1'b0;
    end
  endtask

  task automatic model(input int i, input logic ld, input logic pp, input logic cl,
                       input logic [15:0] d);
    logic [15:0] q[$];
    int n;
    bit pop_ok, push_ok;
    case (i)
      0: q = q0;
      1: q = q1;
      default: q = q2;
    endcase
    if (cl) begin
      q.delete(); last_m[i] = '0; ovf_m[i] = 1'b0; unf_m[i] = 1'b0;
    end else begin
      n       = q.size();
      pop_ok  = pp && (n > 0);
      push_ok = ld && ((n < dep[i]) || pop_ok);
      if (pop_ok) last_m[i] = q.pop_front();
      if (pp && n == 0) unf_m[i] = 1'b1;
      if (ld && !push_ok) ovf_m[i] = 1'b1;
      if (push_ok) q.push_back(d);
    end
    case (i)
      0: q0 = q;
      1: q1 = q;
      default: q2 = q;
    endcase
  endtask

  task automatic check_all(input string tag);
    logic [15:0] q[$];
    logic [31:0] ob, oc, oe, of, oo, ou, eb;
    string pfx;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin q = q0; ob = {16'b0, bo0}; oc = {29'b0, c0}; oe = {31'b0, e0};
                 of = {31'b0, f0}; oo = {31'b0, o0}; ou = {31'b0, u0}; end
        1: begin q = q1; ob = {16'b0, bo1}; oc = {31'b0, c1}; oe = {31'b0, e1};
                 of = {31'b0, f1}; oo = {31'b0, o1}; ou = {31'b0, u1}; end
        default: begin q = q2; ob = {16'b0, bo2}; oc = {30'b0, c2}; oe = {31'b0, e2};
                 of = {31'b0, f2}; oo = {31'b0, o2}; ou = {31'b0, u2}; end
      endcase
      eb  = (q.size() > 0) ? {16'b0, q[0]} : {16'b0, last_m[i]};
      pfx = $sformatf("%s.d%0d", tag, dep[i]);
      chk({pfx, ".br_out"}, ob, eb);
      chk({pfx, ".count"}, oc, 32'(q.size()));
      chk({pfx, ".empty"}, oe, {31'b0, q.size() == 0});
      chk({pfx, ".full"}, of, {31'b0, q.size() == dep[i]});
      chk({pfx, ".overflow"}, oo, {31'b0, ovf_m[i]});
      chk({pfx, ".underflow"}, ou, {31'b0, unf_m[i]});
    end
  endtask

  // One clocked operation: drive on the falling edge, check 1 ns after rising
  task automatic step(input logic ld, input logic pp, input logic cl,
                      input logic [15:0] d, input string tag);
    @(negedge clk);
    cs = '0;
    cs[BR_LOAD_BIT] = ld;
    cs[BR_POP_BIT]  = pp;
    cs[BR_CLR_BIT]  = cl;
    din = d;
    @(posedge clk);
    for (int i = 0; i < 3; i++) model(i, ld, pp, cl, d);
    #1;
    cs = '0;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_all("reset");
    step(1'b0, 1'b0, 1'b0, 16'h0, "idle");
    chk("idle.d4.br_out", {16'b0, bo0}, 32'h0);

    // Asynchronous reset with three words queued, observed before any edge
    step(1'b1, 1'b0, 1'b0, 16'h1111, "pre_rst");
    step(1'b1, 1'b0, 1'b0, 16'h2222, "pre_rst");
    step(1'b1, 1'b0, 1'b0, 16'h3333, "pre_rst");
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst.d4.count", {29'b0, c0}, 32'd0);
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill to full then overflow
    step(1'b1, 1'b0, 1'b0, 16'h1111, "fill");
    step(1'b1, 1'b0, 1'b0, 16'h2222, "fill");
    step(1'b1, 1'b0, 1'b0, 16'h3333, "fill");
    step(1'b1, 1'b0, 1'b0, 16'h4444, "fill");
    chk("fill.d4.full", {31'b0, f0}, 32'd1);
    chk("fill.d4.count", {29'b0, c0}, 32'd4);
    chk("fill.d4.br_out", {16'b0, bo0}, 32'h1111);
    step(1'b1, 1'b0, 1'b0, 16'h5555, "ovf");
    chk("ovf.d4.overflow", {31'b0, o0}, 32'd1);
    chk("ovf.d4.br_out", {16'b0, bo0}, 32'h1111);

    // Drain, hold last popped value, then underflow
    step(1'b0, 1'b1, 1'b0, 16'h0, "drain");
    chk("drain1.d4.br_out", {16'b0, bo0}, 32'h2222);
    step(1'b0, 1'b1, 1'b0, 16'h0, "drain");
    chk("drain2.d4.br_out", {16'b0, bo0}, 32'h3333);
    step(1'b0, 1'b1, 1'b0, 16'h0, "drain");
    chk("drain3.d4.br_out", {16'b0, bo0}, 32'h4444);
    step(1'b0, 1'b1, 1'b0, 16'h0, "drain");
    chk("drain4.d4.br_out", {16'b0, bo0}, 32'h4444);
    chk("drain4.d4.empty", {31'b0, e0}, 32'd1);
    step(1'b0, 1'b1, 1'b0, 16'h0, "unf");
    chk("unf.d4.underflow", {31'b0, u0}, 32'd1);

    // Refill, then simultaneous push+pop while full, with pointer wrap
    step(1'b1, 1'b0, 1'b0, 16'h1111, "refill");
    step(1'b1, 1'b0, 1'b0, 16'h2222, "refill");
    step(1'b1, 1'b0, 1'b0, 16'h3333, "refill");
    step(1'b1, 1'b0, 1'b0, 16'h4444, "refill");
    step(1'b1, 1'b1, 1'b0, 16'hAAAA, "ldpp_full");
    chk("ldpp_full.d4.count", {29'b0, c0}, 32'd4);
    chk("ldpp_full.d4.br_out", {16'b0, bo0}, 32'h2222);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1, 1'b0, 16'hA000 + 16'(k), "wrap");
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0, "wrap_drain");
    end

    // Clear, then push+pop on an empty queue
    step(1'b0, 1'b0, 1'b1, 16'h0, "clr0");
    step(1'b1, 1'b1, 1'b0, 16'hBEEF, "ldpp_empty");
    chk("ldpp_empty.d4.count", {29'b0, c0}, 32'd1);
    chk("ldpp_empty.d4.br_out", {16'b0, bo0}, 32'hBEEF);
    chk("ldpp_empty.d4.underflow", {31'b0, u0}, 32'd1);

    // Overflow, trim to two entries, then clear with a concurrent load
    step(1'b1, 1'b0, 1'b0, 16'hC001, "pre_clr");
    step(1'b1, 1'b0, 1'b0, 16'hC002, "pre_clr");
    step(1'b1, 1'b0, 1'b0, 16'hC003, "pre_clr");
    step(1'b1, 1'b0, 1'b0, 16'hC004, "pre_clr");
    step(1'b0, 1'b1, 1'b0, 16'h0, "pre_clr");
    step(1'b0, 1'b1, 1'b0, 16'h0, "pre_clr");
    chk("pre_clr.d4.count", {29'b0, c0}, 32'd2);
    step(1'b1, 1'b0, 1'b1, 16'h1234, "clr_ld");
    chk("clr_ld.d4.count", {29'b0, c0}, 32'd0);
    chk("clr_ld.d4.br_out", {16'b0, bo0}, 32'h0);
    chk("clr_ld.d4.overflow", {31'b0, o0}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 16'h0, "post_clr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/br_fifo.md
# br_fifo

Parametrised successor to the single buffer register between the MBR and the ALU/register side of the datapath. It captures MBR words under control-word strobes into a DEPTH-entry circular queue, presents the oldest word on `br_out`, and lets the control unit prefetch several operands before consuming them. It also provides an explicit pop, a synchronous clear, occupancy flags and sticky overflow/underflow error bits.

## Interface
- `WIDTH`, 16: data width of each entry.
- `DEPTH`, 4: number of entries, legal range 1–16; any value, not only powers of two.
- `LOAD_BIT`, 7: control_signal bit that requests a push of `mbr_in`.
- `POP_BIT`, 8: control_signal bit that requests removal of the head entry.
- `CLR_BIT`, 9: control_signal bit that requests a synchronous clear.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `control_signal`  in  32  control word; only bits LOAD_BIT, POP_BIT and CLR_BIT are used.
- `mbr_in`  in  WIDTH  data to push.
- `br_out`  out  WIDTH  head entry when not empty, otherwise the last popped value.
- `empty`  out  1  count == 0.
- `full`  out  1  count == DEPTH.
- `count`  out  $clog2(DEPTH+1)  number of valid entries.
- `overflow`  out  1  sticky; a push was dropped.
- `underflow`  out  1  sticky; a pop hit an empty queue.

## Operation
- Strobes: `ld` = control_signal[LOAD_BIT], `pp` = control_signal[POP_BIT], `cl` = control_signal[CLR_BIT].
- Priority:
  - `cl` overrides everything. Pointers, count, `last_q`, `overflow` and `underflow` all go to 0. Entry storage is not cleared.
  - Otherwise the pop and push below are evaluated against the pre-edge count.
- Pop:
  - Accepted when `pp` and !empty.
  - `last_q` ← head entry, and rd_ptr advances.
  - `pp` while empty sets `underflow`; no other state changes.
- Push:
  - Accepted when `ld` and (!full or pop accepted in the same cycle).
  - mem[wr_ptr] ← `mbr_in`, and wr_ptr advances.
  - `ld` while full with no pop drops the data and sets `overflow`.
- Count: +1 on push only, −1 on pop only, unchanged when both or neither occur.
- Simultaneous push and pop on an empty queue: the pop is rejected (`underflow` set) and the push is accepted.
- Pointer wrap: a pointer equal to DEPTH−1 advances to 0.
- `br_out` = empty ? `last_q` : mem[rd_ptr]. This is combinational from registered state; there is no path from the strobes or `mbr_in` to the outputs.
- DEPTH=1 with only LOAD_BIT and POP_BIT strobed together reproduces the legacy single-register behaviour.

## Timing
- Reset (`rst_n` low, asynchronous):
  - rd_ptr, wr_ptr and count = 0, so `empty`=1, `full`=0.
  - `last_q`=0, so `br_out`=0.
  - `overflow`=0, `underflow`=0.
  - Reset asserted mid-sequence discards all queued data immediately, without waiting for a clock edge.
- Push-to-output latency: a word pushed at edge N into an empty queue appears on `br_out` after edge N, visible in cycle N+1. `empty` falls in the same cycle.
- Pop: after the pop edge, `br_out` shows the next entry, or the popped value if the queue is now empty.
- Flags and `count` update on the same edge as the pointer update.
- Sticky error bits set on the offending edge and hold until reset or `cl`.

## Structure
- Shared package `br_pkg`:
  - default WIDTH and DEPTH;
  - the control bit index constants `BR_LOAD_BIT`, `BR_POP_BIT`, `BR_CLR_BIT`, shared with the control unit's microword definition.
- Sub-module `br_ptr_ctr`: a modulo-DEPTH wrapping pointer counter with enable and synchronous clear. It is instantiated twice, for rd_ptr and wr_ptr.
- Storage is a plain register array of DEPTH×WIDTH, no RAM macro.

## Test plan
- Reset, then idle → `br_out`=0x0000, `empty`=1, `count`=0, `overflow`=`underflow`=0. Assert `rst_n` low mid-queue with 3 entries → `count`=0 with no clock edge.
- Push 0x1111, 0x2222, 0x3333, 0x4444 (DEPTH=4) → `full`=1, `count`=4, `br_out`=0x1111. A fifth push of 0x5555 → `overflow`=1, contents unchanged.
- Pop four times → `br_out` shows 0x2222, 0x3333, 0x4444, then 0x4444 held via `last_q` with `empty`=1. A fifth pop → `underflow`=1.
- With `full`, strobe `ld`+`pp` with 0xAAAA → `count` stays 4, `br_out`=0x2222, 0xAAAA is at the tail. Repeat 10 times to exercise pointer wrap; the pop order matches the push order.
- `ld`+`pp` on an empty queue with 0xBEEF → `count`=1, `br_out`=0xBEEF, `underflow`=1.
- `cl`+`ld` with 2 entries and `overflow` set → `count`=0, `br_out`=0, flags 0, push ignored. Repeat the whole suite with DEPTH=1 and DEPTH=3 (non-power-of-two wrap).
